// File: rtl/uart_rx_deframer.sv
// RS232 receive deframer: synchronizes rx, detects the start edge, runs the
// external baud counter via start_bps, samples 8N1 frames LSB first on the
// mid-bit bps strike, and hands each good byte to the CPU through a
// valid/ack holding register with sticky overrun and a one-cycle framing error.
module uart_rx_deframer #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 bps,
  output logic                 start_bps,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int unsigned CntW = $clog2(DATA_BITS) + 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   rx_d_q;
  logic                   fall;

  logic [1:0]             state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [DATA_BITS-1:0]   sh_q, sh_d;
  logic                   start_bps_q;
  logic                   stop_ok, stop_bad;

  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ovr_q, ovr_d;
  logic                   ferr_q;

  assign rx_s = sync_q[SYNC_STAGES-1];
  assign fall = rx_d_q & ~rx_s;

  // Synchronizer and edge flop; preset high so reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      rx_d_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      rx_d_q <= rx_s;
    end
  end

  // Frame FSM next state: start qualify, data shift, stop check.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    case (state_q)
      StIdle: begin
        if (fall) state_d = StStart;
      end
      StStart: begin
        if (bps) begin
          if (!rx_s) begin
            state_d = StData;
            cnt_d   = '0;
          end else begin
            // Line back high at mid-bit: glitch, abandon quietly.
            state_d = StIdle;
          end
        end
      end
      StData: begin
        if (bps) begin
          sh_d  = {rx_s, sh_q[DATA_BITS-1:1]};
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(DATA_BITS - 1)) state_d = StStop;
        end
      end
      StStop: begin
        if (bps) begin
          state_d  = StIdle;
          stop_ok  = rx_s;
          stop_bad = ~rx_s;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Holding register: deliver, drop with overrun, or clear on ack.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (stop_ok) begin
      if (!valid_q || rx_ack) begin
        data_d  = sh_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (rx_ack && valid_q) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sh_q        <= '0;
      start_bps_q <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      ovr_q       <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      // Low in the cycle after the final sample so the baud counter restarts at 0.
      start_bps_q <= (state_d != StIdle);
      data_q      <= data_d;
      valid_q     <= valid_d;
      ovr_q       <= ovr_d;
      ferr_q      <= stop_bad;
    end
  end

  assign start_bps = start_bps_q;
  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign overrun   = ovr_q;
  assign frame_err = ferr_q;

endmodule
